// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the data-memory store buffer.
// Pulled in by both the FIFO and the top-level controller.
package dmem_pkg;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        RD_REQ,
        RD_WAIT,
        RD_DONE
    } dmem_state_e;

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular store queue of {word address, data} entries with a
// youngest-first associative search for load forwarding.
module store_buffer_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int WA     = DEF_ADDR_W - 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WA-1:0]                push_addr,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [WA-1:0]                head_addr,
    output logic [DATA_W-1:0]            head_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty,
    input  logic [WA-1:0]                search_addr,
    output logic                         hit,
    output logic [DATA_W-1:0]            hit_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WA-1:0]     addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     head_reg;
    logic [PW-1:0]     tail_reg;
    logic [CW-1:0]     count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) tail_reg <= tail_reg + 1'b1;
            if (pop)  head_reg <= head_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry storage needs no reset: validity comes from head/count only.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_reg] <= push_addr;
            data_mem[tail_reg] <= push_data;
        end
    end

    // Index gi is entry age (0 = oldest); a later match overrides an earlier one.
    logic [DEPTH-1:0] age_match;
    logic [PW-1:0]    age_slot [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        assign age_slot[gi]  = head_reg + PW'(gi);
        assign age_match[gi] = (CW'(gi) < count_reg) && (addr_mem[age_slot[gi]] == search_addr);
    end

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_match[i]) begin
                hit      = 1'b1;
                hit_data = data_mem[age_slot[i]];
            end
        end
    end

    assign head_addr = addr_mem[head_reg];
    assign head_data = data_mem[head_reg];
    assign count     = count_reg;
    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-store buffer between the MEM stage and a valid/ready data memory:
// stores queue up, loads forward from the queue or wait for drain + read.
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] data_adr,
    input  logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] data_in,
    input  logic              mem_write_to_data_mem,
    input  logic              mem_read_to_data_mem,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WA = ADDR_W - 2;
    localparam int CW = $clog2(DEPTH) + 1;

    dmem_state_e       state_reg, state_next;
    logic [DATA_W-1:0] rdata_reg;

    logic              is_store, is_load, push, pop, drain_req, last_pop;
    logic              full, empty, hit;
    logic [CW-1:0]     count;
    logic [WA-1:0]     head_addr;
    logic [DATA_W-1:0] head_data, hit_data;

    // A simultaneous read+write request is a store; the read is dropped.
    assign is_store  = mem_write_to_data_mem;
    assign is_load   = mem_read_to_data_mem && !mem_write_to_data_mem;
    assign push      = is_store && !full;
    assign drain_req = !empty && (state_reg == IDLE || state_reg == DRAIN);
    assign pop       = drain_req && mem_ready;
    assign last_pop  = pop && (count == CW'(1));

    store_buffer_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .WA     (WA)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_addr   (data_adr[ADDR_W-1:2]),
        .push_data   (data_out),
        .pop         (pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .search_addr (data_adr[ADDR_W-1:2]),
        .hit         (hit),
        .hit_data    (hit_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == RD_WAIT && mem_rvalid) rdata_reg <= mem_rdata;
        end
    end

    // DRAIN also exits when already empty: the IDLE cycle may pop the last entry.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (is_load && !hit) state_next = empty ? RD_REQ : DRAIN;
            DRAIN:   if (empty || last_pop) state_next = RD_REQ;
            RD_REQ:  if (mem_ready) state_next = RD_WAIT;
            RD_WAIT: if (mem_rvalid) state_next = RD_DONE;
            RD_DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall     = 1'b0;
        data_in   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (drain_req) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {head_addr, 2'b00};
            mem_wdata = head_data;
        end
        case (state_reg)
            IDLE: begin
                stall = (is_store && full) || (is_load && !hit);
                if (is_load && hit) data_in = hit_data;
            end
            DRAIN, RD_WAIT: stall = 1'b1;
            RD_REQ: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_we   = 1'b0;
                mem_addr = data_adr;
            end
            RD_DONE: data_in = rdata_reg;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench: an architectural memory model predicts write order and load
// data; a monitor compares whatever the DUT presents on either side.
module tb_dmem_store_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_adr = '0, data_out = '0, data_in;
    logic        mem_write_to_data_mem = 1'b0, mem_read_to_data_mem = 1'b0;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    dmem_store_buffer #(.DEPTH(4), .DATA_W(32), .ADDR_W(32)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .data_adr              (data_adr),
        .data_out              (data_out),
        .data_in               (data_in),
        .mem_write_to_data_mem (mem_write_to_data_mem),
        .mem_read_to_data_mem  (mem_read_to_data_mem),
        .stall                 (stall),
        .mem_req               (mem_req),
        .mem_we                (mem_we),
        .mem_addr              (mem_addr),
        .mem_wdata             (mem_wdata),
        .mem_ready             (mem_ready),
        .mem_rvalid            (mem_rvalid),
        .mem_rdata             (mem_rdata)
    );

    int n_vec = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [29:0] w;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_ld[$];
    logic [31:0] arch     [logic [29:0]];
    logic [31:0] resp_mem [logic [29:0]];

    int          ready_pct = 100;
    int          lat_fixed = 1;
    logic        ld_active = 1'b0;
    logic [31:0] cur_ld_addr = '0;

    function automatic logic [31:0] dflt(input logic [29:0] w);
        return {w[15:0], ~w[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] arch_rd(input logic [29:0] w);
        return arch.exists(w) ? arch[w] : dflt(w);
    endfunction

    function automatic logic [31:0] resp_rd(input logic [29:0] w);
        return resp_mem.exists(w) ? resp_mem[w] : dflt(w);
    endfunction

    // Memory responder: random ready, read data after a 1..N cycle latency.
    int          rd_cnt = 0;
    logic [31:0] rd_val = '0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_ready  = ($urandom_range(99) < ready_pct);
            mem_rvalid = 1'b0;
            if (!rst) rd_cnt = 0;
            else if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd_val;
                end
            end
            @(negedge clk);
            if (rst && mem_req && mem_ready) begin
                if (mem_we) resp_mem[mem_addr[31:2]] = mem_wdata;
                else begin
                    rd_val = resp_rd(mem_addr[31:2]);
                    rd_cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(4, 1));
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mem_req && mem_ready && mem_we) begin
                    if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
                    else begin
                        e = exp_wr.pop_front();
                        check("wr_addr", mem_addr, {e.w, 2'b00});
                        check("wr_data", mem_wdata, e.d);
                    end
                end
                if (mem_req && mem_ready && !mem_we) begin
                    check("rd_before_drain", exp_wr.size(), 0);
                    check("rd_addr", mem_addr, cur_ld_addr);
                end
                if (ld_active && !stall) begin
                    if (exp_ld.size() == 0) check("ld_unexpected", 1, 0);
                    else check("ld_data", data_in, exp_ld.pop_front());
                end
            end
        end
    end

    // kind: 0 store, 1 load, 2 store+load; exp_stall < 0 means don't care.
    task automatic op(input int kind, input logic [31:0] a, input logic [31:0] d, input int exp_stall);
        int   cyc = 0;
        bit   done = 0;
        bit   first = 1;
        wr_t  e;
        data_adr = a;
        data_out = d;
        mem_write_to_data_mem = (kind != 1);
        mem_read_to_data_mem  = (kind != 0);
        if (kind == 1) begin
            cur_ld_addr = a;
            exp_ld.push_back(arch_rd(a[31:2]));
            ld_active = 1'b1;
        end else begin
            arch[a[31:2]] = d;
            e.w = a[31:2];
            e.d = d;
            exp_wr.push_back(e);
        end
        while (!done) begin
            @(negedge clk);
            if (first && exp_stall >= 0) check("first_stall", stall, 64'(exp_stall));
            first = 0;
            if (!stall) done = 1;
            else if (++cyc > 300) begin
                check("op_timeout", 1, 0);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
        mem_write_to_data_mem = 1'b0;
        mem_read_to_data_mem  = 1'b0;
        ld_active = 1'b0;
        data_adr  = '0;
        data_out  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain_wait();
        int c = 0;
        while (exp_wr.size() != 0 && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain_done", exp_wr.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r;
        logic [31:0] a;
        #1 rst = 1'b0;
        #11;
        check("rst_stall", stall, 0);
        check("rst_data_in", data_in, 0);
        check("rst_mem_req", mem_req, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // single posted store, memory always ready
        ready_pct = 100;
        lat_fixed = 1;
        idle(1);
        op(0, 32'h100, 32'hDEADBEEF, 0);
        drain_wait();

        // fill the buffer with memory blocked; fifth store stalls until ready returns
        ready_pct = 0;
        idle(1);
        for (int i = 0; i < 4; i++) op(0, 32'(i * 4), $urandom, 0);
        fork
            op(0, 32'h10, $urandom, 1);
            begin
                repeat (4) @(posedge clk);
                ready_pct = 100;
            end
        join
        drain_wait();

        // youngest buffered store is forwarded to a load in the same cycle
        ready_pct = 0;
        idle(1);
        op(0, 32'h20, 32'h11, 0);
        op(0, 32'h20, 32'h22, 0);
        op(1, 32'h20, 32'h0, 0);
        ready_pct = 100;
        drain_wait();

        // load miss from an empty buffer, 3-cycle read latency
        resp_mem[30'h10] = 32'hCAFEF00D;
        arch[30'h10]     = 32'hCAFEF00D;
        lat_fixed = 3;
        op(1, 32'h40, 32'h0, 1);
        lat_fixed = 1;

        // load miss behind two buffered stores: read only after both drain
        ready_pct = 0;
        idle(1);
        op(0, 32'h0, 32'h1234_5678, 0);
        op(0, 32'h4, 32'h9ABC_DEF0, 0);
        fork
            op(1, 32'h80, 32'h0, 1);
            begin
                repeat (5) @(posedge clk);
                ready_pct = 100;
            end
        join

        // reset with two stores buffered discards them at once
        ready_pct = 0;
        idle(1);
        op(0, 32'h300, 32'hAAAA_0001, 0);
        op(0, 32'h304, 32'hAAAA_0002, 0);
        @(negedge clk);
        check("pre_rst_req", mem_req, 1);
        rst = 1'b0;
        #1;
        check("rst_buf_req", mem_req, 0);
        check("rst_buf_stall", stall, 0);
        exp_wr.delete();
        arch = resp_mem;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        ready_pct = 100;
        op(1, 32'h300, 32'h0, 1);

        // reset while waiting for read data aborts the read
        lat_fixed = 20;
        cur_ld_addr = 32'h400;
        data_adr = 32'h400;
        mem_read_to_data_mem = 1'b1;
        repeat (3) @(negedge clk);
        check("rdwait_stall", stall, 1);
        check("rdwait_req", mem_req, 0);
        rst = 1'b0;
        mem_read_to_data_mem = 1'b0;
        data_adr = '0;
        #1;
        check("rst_rd_req", mem_req, 0);
        check("rst_rd_stall", stall, 0);
        check("rst_rd_data", data_in, 0);
        arch = resp_mem;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        lat_fixed = 1;
        op(1, 32'h400, 32'h0, 1);

        // randomized traffic over a small address window
        lat_fixed = 0;
        for (int p = 0; p < 4; p++) begin
            ready_pct = (p == 0) ? 100 : int'($urandom_range(90, 20));
            for (int k = 0; k < 80; k++) begin
                r = int'($urandom_range(9));
                a = ($urandom_range(7) << 2) | $urandom_range(3);
                if (r < 4)       op(0, a, $urandom, -1);
                else if (r < 8)  op(1, a, 32'h0, -1);
                else if (r == 8) op(2, a, $urandom, -1);
                else             idle(1);
            end
        end
        ready_pct = 100;
        drain_wait();
        idle(5);
        check("ld_leftover", exp_ld.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
